// File: rtl/axil_reg_slave.sv
// rtl/axil_reg_slave.sv - AXI4-Lite register bank responder
// Write address and data are captured independently and commit together; reads return pre-commit contents.
module axil_reg_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REGS   = 16
) (
  input  logic                    s0_axi_aclk,
  input  logic                    s0_axi_areset,
  input  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr,
  input  logic                    s0_axi_awvalid,
  output logic                    s0_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s0_axi_wdata,
  input  logic [DATA_WIDTH/8:0]   s0_axi_wstrb,
  input  logic                    s0_axi_wvalid,
  output logic                    s0_axi_wready,
  output logic                    s0_axi_bresp,
  output logic                    s0_axi_bvalid,
  input  logic                    s0_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s0_axi_araddr,
  input  logic                    s0_axi_arvalid,
  output logic                    s0_axi_arready,
  output logic [DATA_WIDTH-1:0]   s0_axi_rdata,
  output logic                    s0_axi_rresp,
  output logic                    s0_axi_rvalid,
  input  logic                    s0_axi_rready
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int IDX_W = ADDR_WIDTH - 2;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  aw_held, w_held;
  logic [IDX_W-1:0]      aw_idx_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [NB-1:0]         w_strb_q;

  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0] wr_data, rd_val;
  logic [NB-1:0]         wr_strb;
  logic                  wr_in_range, rd_in_range;
  logic                  unused_bits;

  // Byte offsets and the spare strobe MSB carry no meaning here.
  assign unused_bits = ^{s0_axi_wstrb[NB], s0_axi_awaddr[1:0], s0_axi_araddr[1:0]};

  assign s0_axi_awready = !aw_held && !s0_axi_bvalid;
  assign s0_axi_wready  = !w_held && !s0_axi_bvalid;
  assign s0_axi_arready = !s0_axi_rvalid;

  assign aw_hs  = s0_axi_awvalid && s0_axi_awready;
  assign w_hs   = s0_axi_wvalid && s0_axi_wready;
  assign ar_hs  = s0_axi_arvalid && s0_axi_arready;
  assign commit = (aw_held || aw_hs) && (w_held || w_hs);

  // Held values take priority over the live bus for whichever half arrived first.
  assign wr_idx  = aw_held ? aw_idx_q : s0_axi_awaddr[ADDR_WIDTH-1:2];
  assign wr_data = w_held ? w_data_q : s0_axi_wdata;
  assign wr_strb = w_held ? w_strb_q : s0_axi_wstrb[NB-1:0];
  assign rd_idx  = s0_axi_araddr[ADDR_WIDTH-1:2];

  assign wr_in_range = {1'b0, wr_idx} < (IDX_W+1)'(NUM_REGS);
  assign rd_in_range = {1'b0, rd_idx} < (IDX_W+1)'(NUM_REGS);

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (rd_idx == IDX_W'(i)) rd_val = regs[i];
  end

  always_ff @(posedge s0_axi_aclk) begin
    if (s0_axi_areset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_idx_q      <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      s0_axi_bvalid <= 1'b0;
      s0_axi_bresp  <= 1'b0;
      s0_axi_rvalid <= 1'b0;
      s0_axi_rresp  <= 1'b0;
      s0_axi_rdata  <= '0;
    end else begin
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        for (int i = 0; i < NUM_REGS; i++)
          if (wr_idx == IDX_W'(i))
            for (int b = 0; b < NB; b++)
              if (wr_strb[b]) regs[i][8*b +: 8] <= wr_data[8*b +: 8];
        s0_axi_bvalid <= 1'b1;
        s0_axi_bresp  <= !wr_in_range;
      end else begin
        if (aw_hs) begin
          aw_held  <= 1'b1;
          aw_idx_q <= s0_axi_awaddr[ADDR_WIDTH-1:2];
        end
        if (w_hs) begin
          w_held   <= 1'b1;
          w_data_q <= s0_axi_wdata;
          w_strb_q <= s0_axi_wstrb[NB-1:0];
        end
        if (s0_axi_bvalid && s0_axi_bready) s0_axi_bvalid <= 1'b0;
      end

      // rd_val samples regs before this edge's commit lands.
      if (ar_hs) begin
        s0_axi_rvalid <= 1'b1;
        s0_axi_rdata  <= rd_in_range ? rd_val : '0;
        s0_axi_rresp  <= !rd_in_range;
      end else if (s0_axi_rvalid && s0_axi_rready) begin
        s0_axi_rvalid <= 1'b0;
      end
    end
  end

endmodule
